bunch_strobe_gen: RTL and testbench

- Timing front-end that drives the integrate/mux block's `bunch_strb` and `sel` inputs.
- On a trigger it waits a programmable delay, then emits a train of 1..8 strobe windows.
- Each window has a programmable length, and windows are separated by a gap long enough for the integrator's post-strobe clear to complete.
- For each bunch it issues a 2-bit channel select and a `result_valid` pulse aligned to the cycle in which the integrator's registered outputs hold that bunch's final sum.

---
 rtl/bunch_strobe_gen.sv | 205 ++++++++++++++++++++
 tb/tb_bunch_strobe_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bunch_strobe_gen.sv
// Bunch strobe generator: trigger -> start delay -> train of 1..8 integration windows
// with per-bunch channel select and result_valid aligned to the integrator output.
// Optional trigger/miss counters are compiled in with `define BUNCH_TRIG_CNT_EN.
module bunch_strobe_gen #(
  parameter int DLY_W   = 10,
  parameter int GAP_W   = 8,
  parameter int MIN_GAP = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [DLY_W-1:0] start_dly,
  input  logic [5:0]       strb_len,
  input  logic [GAP_W-1:0] bunch_gap,
  input  logic [2:0]       n_bunch,
  input  logic [15:0]      sel_pattern,
  output logic             bunch_strb,
  output logic [1:0]       sel,
  output logic [2:0]       bunch_idx,
  output logic             result_valid,
  output logic             busy,
  output logic             trig_missed
`ifdef BUNCH_TRIG_CNT_EN
  , output logic [15:0]    trig_count
  , output logic [7:0]     miss_count
`endif
);

  localparam int W_DG  = (DLY_W > GAP_W) ? DLY_W : GAP_W;
  localparam int CNT_W = (W_DG > 6) ? W_DG : 6;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_GAP_CW = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] MIN_GAP_M1 = CNT_W'(MIN_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    STROBE,
    GAP,
    TAIL
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  // Train configuration captured at trigger acceptance, stored as (cycles - 1).
  logic [5:0]       lat_len_m1;
  logic [CNT_W-1:0] lat_gap_m1;
  logic [2:0]       lat_nb;
  logic [15:0]      lat_pat;

  logic [5:0]       len_m1_in;
  logic [CNT_W-1:0] gap_ext;
  logic [CNT_W-1:0] gap_m1_in;
  logic [2:0]       next_slot;

  logic             load;
  logic             gap_entry;
  logic             strb_fall;
  logic             rv_p1;
  logic             inc_p1;
  logic             inc_p2;

  assign len_m1_in = (strb_len == 6'd0) ? 6'd0 : strb_len - 6'd1;
  assign gap_ext   = CNT_W'(bunch_gap);
  assign gap_m1_in = (gap_ext < MIN_GAP_CW) ? MIN_GAP_M1 : gap_ext - CNT_ONE;
  assign next_slot = bunch_idx + 3'd1;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load      = 1'b0;
    gap_entry = 1'b0;
    strb_fall = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          load = 1'b1;
          if (start_dly == '0) begin
            state_nx = STROBE;
            cnt_nx   = CNT_W'(len_m1_in);
          end else begin
            state_nx = DELAY;
            cnt_nx   = CNT_W'(start_dly) - CNT_ONE;
          end
        end
      end
      DELAY: begin
        if (cnt == '0) begin
          state_nx = STROBE;
          cnt_nx   = CNT_W'(lat_len_m1);
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          strb_fall = 1'b1;
          if (bunch_idx < lat_nb) begin
            state_nx  = GAP;
            cnt_nx    = lat_gap_m1;
            gap_entry = 1'b1;
          end else begin
            state_nx = TAIL;
            cnt_nx   = MIN_GAP_M1;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nx = STROBE;
          cnt_nx   = CNT_W'(lat_len_m1);
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      TAIL: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_len_m1   <= '0;
      lat_gap_m1   <= '0;
      lat_nb       <= '0;
      lat_pat      <= '0;
      rv_p1        <= 1'b0;
      inc_p1       <= 1'b0;
      inc_p2       <= 1'b0;
      bunch_strb   <= 1'b0;
      sel          <= '0;
      bunch_idx    <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      trig_missed  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;

      if (load) begin
        lat_len_m1 <= len_m1_in;
        lat_gap_m1 <= gap_m1_in;
        lat_nb     <= n_bunch;
        lat_pat    <= sel_pattern;
      end

      bunch_strb  <= (state_nx == STROBE);
      busy        <= (state_nx != IDLE);
      trig_missed <= trig && (state != IDLE);

      // Two-stage delay matches the integrator's accumulate + output registers.
      rv_p1        <= strb_fall;
      result_valid <= rv_p1;
      inc_p1       <= gap_entry;
      inc_p2       <= inc_p1;

      if (load) begin
        bunch_idx <= '0;
        sel       <= sel_pattern[1:0];
      end else begin
        if (gap_entry) begin
          sel <= lat_pat[{next_slot, 1'b0} +: 2];
        end
        if (inc_p2) begin
          bunch_idx <= next_slot;
        end
      end
    end
  end

`ifdef BUNCH_TRIG_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_count <= '0;
      miss_count <= '0;
    end else begin
      if (load) begin
        trig_count <= trig_count + 16'd1;
      end
      if (trig && (state != IDLE) && (miss_count != 8'hFF)) begin
        miss_count <= miss_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bunch_strobe_gen.sv
// Directed bench for bunch_strobe_gen: table of trains (timing, select, result_valid,
// busy, missed triggers) plus a hand-written mid-train reset sequence.
module tb_bunch_strobe_gen;

  localparam int DLY_W = 10;
  localparam int GAP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             trig;
  logic [DLY_W-1:0] start_dly;
  logic [5:0]       strb_len;
  logic [GAP_W-1:0] bunch_gap;
  logic [2:0]       n_bunch;
  logic [15:0]      sel_pattern;
  logic             bunch_strb;
  logic [1:0]       sel;
  logic [2:0]       bunch_idx;
  logic             result_valid;
  logic             busy;
  logic             trig_missed;
`ifdef BUNCH_TRIG_CNT_EN
  logic [15:0]      trig_count;
  logic [7:0]       miss_count;
`endif

  bunch_strobe_gen #(.DLY_W(DLY_W), .GAP_W(GAP_W), .MIN_GAP(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .trig         (trig),
    .start_dly    (start_dly),
    .strb_len     (strb_len),
    .bunch_gap    (bunch_gap),
    .n_bunch      (n_bunch),
    .sel_pattern  (sel_pattern),
    .bunch_strb   (bunch_strb),
    .sel          (sel),
    .bunch_idx    (bunch_idx),
    .result_valid (result_valid),
    .busy         (busy),
    .trig_missed  (trig_missed)
`ifdef BUNCH_TRIG_CNT_EN
    , .trig_count (trig_count)
    , .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs plus hand-computed effective strobe length, gap and busy duration.
  typedef struct {
    int          dly;
    int          len;
    int          gap;
    int          nb_m1;
    logic [15:0] pat;
    int          exp_len;
    int          exp_gap;
    int          exp_busy;
    int          miss_at;
  } vec_t;

  vec_t vecs[7];

  // Sample index i is the cycle after trigger edge k + i (spec cycle k+1+i).
  task automatic run_vec(input vec_t v, input int vi);
    int   rise[8], fall[8], rvi[8], rvb[8], sel_r[8];
    int   nr = 0, nf = 0, nrv = 0, nmiss = 0, miss_i = -1, busy_n = 0;
    int   nb = v.nb_m1 + 1;
    int   limit = v.exp_busy + 6;
    bit   prev = 1'b0;
    bit   sel_bad = 1'b0;
    logic [1:0] cur_sel = 2'd0;
    logic [15:0] pat = v.pat;
`ifdef BUNCH_TRIG_CNT_EN
    logic [15:0] tc0 = trig_count;
    logic [7:0]  mc0 = miss_count;
`endif
    start_dly   = DLY_W'(v.dly);
    strb_len    = 6'(v.len);
    bunch_gap   = GAP_W'(v.gap);
    n_bunch     = 3'(v.nb_m1);
    sel_pattern = v.pat;
    trig        = 1'b1;
    @(negedge clk);
    trig        = 1'b0;
    start_dly   = ~DLY_W'(v.dly);
    strb_len    = 6'd0;
    bunch_gap   = '0;
    n_bunch     = 3'd0;
    sel_pattern = ~v.pat;
    check($sformatf("v%0d busy_at_accept", vi), busy, 1);
    check($sformatf("v%0d idx_at_accept", vi), bunch_idx, 0);
    check($sformatf("v%0d sel_at_accept", vi), sel, pat[1:0]);
    for (int i = 0; i < limit; i++) begin
      if (busy) busy_n++;
      if (bunch_strb && !prev) begin
        if (nr < 8) begin
          rise[nr]  = i;
          sel_r[nr] = sel;
        end
        nr++;
        cur_sel = sel;
      end
      if (bunch_strb && sel !== cur_sel) sel_bad = 1'b1;
      if (!bunch_strb && prev) begin
        if (nf < 8) fall[nf] = i;
        nf++;
      end
      if (result_valid) begin
        if (nrv < 8) begin
          rvi[nrv] = i;
          rvb[nrv] = bunch_idx;
        end
        nrv++;
      end
      if (trig_missed) begin
        nmiss++;
        miss_i = i;
      end
      prev = bunch_strb;
      trig = (i == v.miss_at);
      @(negedge clk);
    end
    trig = 1'b0;
    check($sformatf("v%0d strobes", vi), nr, nb);
    check($sformatf("v%0d results", vi), nrv, nb);
    for (int b = 0; b < nb && b < 8; b++) begin
      int r = v.dly + b * (v.exp_len + v.exp_gap);
      check($sformatf("v%0d b%0d rise", vi, b), rise[b], r);
      check($sformatf("v%0d b%0d fall", vi, b), fall[b], r + v.exp_len);
      check($sformatf("v%0d b%0d sel", vi, b), sel_r[b], pat[2*b +: 2]);
      check($sformatf("v%0d b%0d rv_cycle", vi, b), rvi[b], r + v.exp_len + 1);
      check($sformatf("v%0d b%0d rv_idx", vi, b), rvb[b], b);
    end
    check($sformatf("v%0d sel_stable", vi), sel_bad, 0);
    check($sformatf("v%0d busy_len", vi), busy_n, v.exp_busy);
    check($sformatf("v%0d busy_end", vi), busy, 0);
    check($sformatf("v%0d sel_held", vi), sel, pat[2*v.nb_m1 +: 2]);
    check($sformatf("v%0d miss_pulses", vi), nmiss, (v.miss_at >= 0) ? 1 : 0);
    if (v.miss_at >= 0)
      check($sformatf("v%0d miss_cycle", vi), miss_i, v.miss_at + 1);
`ifdef BUNCH_TRIG_CNT_EN
    check($sformatf("v%0d trig_count", vi), trig_count, tc0 + 16'd1);
    check($sformatf("v%0d miss_count", vi), miss_count, mc0 + ((v.miss_at >= 0) ? 8'd1 : 8'd0));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found = 1'b0;
    int rv_after = 0;
    int busy_after = 0;
    int nrise = 0;
    bit prev = 1'b0;

    //            dly   len gap nb  pat      len gap busy  miss
    vecs[0] = '{    5,   4,  0, 0, 16'h0002,  4, 11,   20,  -1};
    vecs[1] = '{    0,   0, 20, 2, 16'h0024,  1, 20,   54,  -1};
    vecs[2] = '{    2,   8,  3, 1, 16'h000D,  8, 11,   40,  -1};
    vecs[3] = '{ 1023,  63,255, 7, 16'h1B1B, 63,255, 3323,  -1};
    vecs[4] = '{    3,   2, 12, 1, 16'h0008,  2, 12,   30,  -1};
    vecs[5] = '{    0,   4, 11, 2, 16'h0039,  4, 11,   45,  16};
    vecs[6] = '{    2,   3, 15, 3, 16'h00E4,  3, 15,   70,  -1};

    rst = 1'b1;
    trig = 1'b0;
    start_dly = '0;
    strb_len = '0;
    bunch_gap = '0;
    n_bunch = '0;
    sel_pattern = '0;
    repeat (3) @(negedge clk);
    check("rst bunch_strb", bunch_strb, 0);
    check("rst sel", sel, 0);
    check("rst bunch_idx", bunch_idx, 0);
    check("rst result_valid", result_valid, 0);
    check("rst busy", busy, 0);
    check("rst trig_missed", trig_missed, 0);
`ifdef BUNCH_TRIG_CNT_EN
    check("rst trig_count", trig_count, 0);
    check("rst miss_count", miss_count, 0);
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle busy", busy, 0);

    for (int v = 0; v < 7; v++) begin
      run_vec(vecs[v], v);
      repeat (2) @(negedge clk);
    end

    // Five-bunch train, reset asserted asynchronously during the third strobe.
    start_dly = '0;
    strb_len = 6'd3;
    bunch_gap = GAP_W'(11);
    n_bunch = 3'd4;
    sel_pattern = 16'h0030;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bunch_strb && !prev) nrise++;
      prev = bunch_strb;
      if (nrise == 3) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid third_strobe_seen", found, 1);
    check("rst_mid sel_before", sel, 3);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid bunch_strb", bunch_strb, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid sel", sel, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (result_valid) rv_after++;
      if (busy) busy_after++;
      @(negedge clk);
    end
    check("rst_mid no_result_valid", rv_after, 0);
    check("rst_mid stays_idle", busy_after, 0);

    run_vec(vecs[1], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
